xnor_descrambler: RTL and testbench
===================================

// Module: xnor_descrambler
// PURPOSE
// - Receive end of the mini-ALU XNOR scrambled link: recovers 6-bit plaintext words that the
//   transmitter encoded as tx = data ~^ keystream.
// - Keystream is a 6-bit Fibonacci LFSR advanced once per accepted word; XNOR is self-inverse,
//   so out = in ~^ keystream.
// - Sits between the link input and the ALU operand registers.
// - Valid/ready on both sides; one registered output stage.
// PARAMETERS
// - WIDTH      6   data/keystream width; the LFSR taps below are fixed for 6.
// - FRAME_LEN  16  words per frame, >=1. After the last word the LFSR reloads the stored seed.
// PORTS
// - clk        in   1      rising-edge clock
// - rst_n      in   1      asynchronous active-low reset
// - seed_load  in   1      1-cycle strobe: latch seed_in, restart frame
// - seed_in    in   WIDTH  LFSR seed; 6'h00 is substituted by 6'h01
// - in_valid   in   1      scrambled word present
// - in_data    in   WIDTH  scrambled word
// - in_ready   out  1      word accepted when in_valid && in_ready
// - out_valid  out  1      descrambled word held
// - out_data   out  WIDTH  descrambled word
// - out_last   out  1      out_data is the final word of the frame
// - out_ready  in   1      downstream accepts when out_valid && out_ready
// - word_cnt   out  4      index of the next word in the frame, 0..FRAME_LEN-1
// BEHAVIOUR
// - Reset (async assert, sync release): state=IDLE, lfsr=6'h01, seed_reg=6'h01, word_cnt=0,
//   out_valid=0, out_data=0, out_last=0.
// - States:
//   - IDLE: no seed yet, in_ready=0. seed_load -> RUN.
//   - RUN: stays in RUN; there is no exit except reset.
// - seed_load (either state): seed_reg and lfsr <= (seed_in==0 ? 6'h01 : seed_in); word_cnt <= 0.
//   A held output word is kept untouched.
// - in_ready = (state==RUN) && !seed_load && (!out_valid || out_ready).
//   - seed_load has priority: an input offered in the same cycle is not accepted.
// - On accept (registered, latency 1 cycle from accept to out_valid):
//   - out_data <= in_data ~^ lfsr; out_valid <= 1; out_last <= (word_cnt==FRAME_LEN-1).
//   - If word_cnt==FRAME_LEN-1: word_cnt <= 0 and lfsr <= seed_reg.
//   - Otherwise: word_cnt++ and lfsr <= {lfsr[4:0], lfsr[5]^lfsr[4]}.
// - Output: out_valid, out_data and out_last are held stable while out_valid && !out_ready.
//   - Handshake with no new accept: out_valid <= 0.
//   - Handshake with a new accept in the same cycle: the new word replaces the old one;
//     back-to-back throughput is 1 word/clk.
// - Stall: the LFSR and word_cnt advance only on accept, never on idle or stalled cycles.
// - FRAME_LEN=1: every word uses the seed as keystream and every word has out_last=1.
// - Reset mid-frame: all state is cleared and the block returns to IDLE; a new seed_load is
//   required before any input is accepted.
// TESTING
// - Reset, no seed, in_valid=1 for 10 clk -> in_ready stays 0, out_valid stays 0.
// - seed 6'h01, in 6'h2A then 6'h00, out_ready=1 -> out 6'h14 then 6'h3D, each 1 clk after accept.
// - FRAME_LEN=4, seed 01, five words of 6'h00 -> out 3E,3D,3B,37 (out_last on 37), then 3E.
// - out_ready=0 for 5 clk with 2 words offered -> first word held stable, in_ready=0,
//   no LFSR advance; release -> both words correct and in order.
// - seed_load with in_valid in the same cycle -> word not accepted; next cycle it is decoded
//   with keystream = new seed. seed_in=0 -> keystream 6'h01.
// - rst_n low mid-frame after 2 words -> outputs cleared at once, IDLE; after reseed,
//   word_cnt restarts at 0.

Source files
------------

// File: rtl/xnor_descrambler_if.sv
// ---------------------------------------------------------------------------
// xnor_descrambler_if
// Bundles the seed strobe, the scrambled input stream and the descrambled
// output stream of the XNOR descrambler.
//
// Handshake rule (both streams): a word moves on a rising clock edge where
// valid && ready are both high. The producer holds valid and data stable
// until that edge. Ready may depend combinationally on the other side's
// ready, but valid never depends on ready.
//
// Signals
//   seed_load  master->slave  1-cycle strobe: latch seed_in, restart frame
//   seed_in    master->slave  LFSR seed (zero is replaced by 1)
//   in_valid   master->slave  scrambled word present
//   in_data    master->slave  scrambled word
//   in_ready   slave->master  slave can take in_data this cycle
//   out_valid  slave->master  descrambled word held
//   out_data   slave->master  descrambled word
//   out_last   slave->master  out_data is the final word of its frame
//   out_ready  master->slave  downstream takes out_data this cycle
//   word_cnt   slave->master  frame index of the next word to be accepted
// ---------------------------------------------------------------------------
interface xnor_descrambler_if #(
  parameter int WIDTH = 6
);
  logic             seed_load;
  logic [WIDTH-1:0] seed_in;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_ready;
  logic [3:0]       word_cnt;

  modport master (
    output seed_load, seed_in, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last, word_cnt
  );

  modport slave (
    input  seed_load, seed_in, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last, word_cnt
  );
endinterface

// File: rtl/xnor_descrambler.sv
// ---------------------------------------------------------------------------
// xnor_descrambler
// Receive side of the XNOR-scrambled link feeding the ALU operand registers.
// Each accepted word is XNORed with a 6-bit Fibonacci LFSR keystream; the
// LFSR advances once per accepted word and reloads the stored seed after the
// last word of a frame. One registered output stage, 1 word/clk throughput.
//
// Ports
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      xnor_descrambler_if.slave (seed, input and output streams)
//   o_state  current FSM state (0 = IDLE, 1 = RUN) for observation
// ---------------------------------------------------------------------------
module xnor_descrambler #(
  parameter int WIDTH     = 6,
  parameter int FRAME_LEN = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  xnor_descrambler_if.slave   bus,
  output logic                o_state
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] LAST_IDX = 4'(FRAME_LEN - 1);

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] r_seed;
  logic [3:0]       r_word_cnt;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_last;

  logic             w_in_ready;
  logic             w_accept;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_lfsr_step;
  logic             w_frame_end;

  // An all-zero seed would lock the LFSR, so it is replaced by 1.
  assign w_seed      = (bus.seed_in == '0) ? WIDTH'(1) : bus.seed_in;
  // Taps on the two top bits, feedback shifted in at bit 0.
  assign w_lfsr_step = {r_lfsr[WIDTH-2:0], r_lfsr[WIDTH-1] ^ r_lfsr[WIDTH-2]};
  assign w_frame_end = (r_word_cnt == LAST_IDX);
  assign w_accept    = bus.in_valid && w_in_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: the first seed moves to RUN, only reset leaves RUN.
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE && bus.seed_load) begin
      w_state_next = ST_RUN;
    end
  end

  // Output logic: a seed strobe blocks input for its cycle so the word
  // offered alongside it is decoded with the new seed one cycle later.
  always_comb begin
    w_in_ready = 1'b0;
    if (r_state == ST_RUN && !bus.seed_load && (!r_out_valid || bus.out_ready)) begin
      w_in_ready = 1'b1;
    end
  end

  // Keystream and frame position
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seed     <= WIDTH'(1);
      r_lfsr     <= WIDTH'(1);
      r_word_cnt <= '0;
    end else if (bus.seed_load) begin
      r_seed     <= w_seed;
      r_lfsr     <= w_seed;
      r_word_cnt <= '0;
    end else if (w_accept) begin
      if (w_frame_end) begin
        r_word_cnt <= '0;
        r_lfsr     <= r_seed;
      end else begin
        r_word_cnt <= r_word_cnt + 4'd1;
        r_lfsr     <= w_lfsr_step;
      end
    end
  end

  // Output stage: a new accept overwrites the word leaving in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_accept) begin
      r_out_valid <= 1'b1;
      r_out_data  <= bus.in_data ~^ r_lfsr;
      r_out_last  <= w_frame_end;
    end else if (r_out_valid && bus.out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_data  = r_out_data;
  assign bus.out_last  = r_out_last;
  assign bus.word_cnt  = r_word_cnt;
  assign o_state       = r_state;

endmodule

// File: tb/tb_xnor_descrambler.sv
// ---------------------------------------------------------------------------
// tb_xnor_descrambler
// Drives one stimulus stream into two descramblers (FRAME_LEN 16 and 4) and
// checks them against a keystream model computed from the frame position.
// Inputs change 1 time unit after the rising edge; combinational outputs are
// sampled on the falling edge, registered outputs after the rising edge.
// ---------------------------------------------------------------------------
module tb_xnor_descrambler;

  logic       clk;
  logic       rst_n;
  logic       seed_load;
  logic [5:0] seed_in;
  logic       in_valid;
  logic [5:0] in_data;
  logic       out_ready;
  logic       state16;
  logic       state4;

  int n_checks;
  int n_fail;

  logic [6:0] exp_q[$];

  xnor_descrambler_if #(.WIDTH(6)) if16 ();
  xnor_descrambler_if #(.WIDTH(6)) if4 ();

  assign if16.seed_load = seed_load;
  assign if16.seed_in   = seed_in;
  assign if16.in_valid  = in_valid;
  assign if16.in_data   = in_data;
  assign if16.out_ready = out_ready;
  assign if4.seed_load  = seed_load;
  assign if4.seed_in    = seed_in;
  assign if4.in_valid   = in_valid;
  assign if4.in_data    = in_data;
  assign if4.out_ready  = out_ready;

  xnor_descrambler #(.WIDTH(6), .FRAME_LEN(16)) dut16 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if16.slave),
    .o_state (state16)
  );

  xnor_descrambler #(.WIDTH(6), .FRAME_LEN(4)) dut4 (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (if4.slave),
    .o_state (state4)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Keystream for word k of a frame: seed advanced k times.
  function automatic logic [5:0] ks(input logic [5:0] seed, input int k);
    logic [5:0] s;
    s = seed;
    for (int i = 0; i < k; i++) s = {s[4:0], s[5] ^ s[4]};
    return s;
  endfunction

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_seed(input logic [5:0] s);
    seed_load = 1'b1;
    seed_in   = s;
    tick();
    seed_load = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    seed_load = 1'b0; seed_in = 6'h00; in_valid = 1'b0; in_data = 6'h00; out_ready = 1'b0;
    tick(); tick();
    n_checks++;
    if (if16.out_valid !== 1'b0 || if16.out_data !== 6'h00 || if16.out_last !== 1'b0 ||
        if16.word_cnt !== 4'd0 || state16 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state16: valid=%b data=%h last=%b cnt=%0d st=%b, required 0 00 0 0 0",
               if16.out_valid, if16.out_data, if16.out_last, if16.word_cnt, state16);
    end
    n_checks++;
    if (if4.out_valid !== 1'b0 || if4.out_data !== 6'h00 || if4.out_last !== 1'b0 ||
        if4.word_cnt !== 4'd0 || state4 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_state4: valid=%b data=%h last=%b cnt=%0d st=%b, required 0 00 0 0 0",
               if4.out_valid, if4.out_data, if4.out_last, if4.word_cnt, state4);
    end
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = 6'h2A; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_checks++;
      if (if16.in_ready !== 1'b0 || if4.in_ready !== 1'b0 ||
          if16.out_valid !== 1'b0 || if4.out_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL noseed_idle cyc %0d: in_ready=%b/%b out_valid=%b/%b, required all 0",
                 i, if16.in_ready, if4.in_ready, if16.out_valid, if4.out_valid);
      end
      tick();
    end
    in_valid = 1'b0;
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    do_seed(6'h01);
    in_valid = 1'b1; in_data = 6'h2A;
    @(negedge clk);
    n_checks++;
    if (if16.in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ready: in_ready=%b, required 1", if16.in_ready);
    end
    tick();
    in_data = 6'h00;
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== 6'h14 || if16.word_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL basic_word0: valid=%b data=%h cnt=%0d, required 1 14 1",
               if16.out_valid, if16.out_data, if16.word_cnt);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== 6'h3D || if16.out_last !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_word1: valid=%b data=%h last=%b, required 1 3d 0",
               if16.out_valid, if16.out_data, if16.out_last);
    end
    tick();
    n_checks++;
    if (if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_drain: out_valid=%b, required 0", if16.out_valid);
    end
  endtask

  task automatic test_frame();
    logic [5:0] exp4 [5];
    exp4[0] = 6'h3E; exp4[1] = 6'h3D; exp4[2] = 6'h3B; exp4[3] = 6'h37; exp4[4] = 6'h3E;
    out_ready = 1'b1;
    do_seed(6'h01);
    in_valid = 1'b1; in_data = 6'h00;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_checks++;
      if (if4.out_valid !== 1'b1 || if4.out_data !== exp4[k] || if4.out_last !== (k == 3)) begin
        n_fail++;
        $display("FAIL frame4 word %0d: valid=%b data=%h last=%b, required 1 %h %b",
                 k, if4.out_valid, if4.out_data, if4.out_last, exp4[k], (k == 3));
      end
      n_checks++;
      if (if16.out_data !== ~ks(6'h01, k) || if16.out_last !== 1'b0) begin
        n_fail++;
        $display("FAIL frame16 word %0d: data=%h last=%b, required %h 0",
                 k, if16.out_data, if16.out_last, ~ks(6'h01, k));
      end
    end
    in_valid = 1'b0;
    n_checks++;
    if (if4.word_cnt !== 4'd1 || if16.word_cnt !== 4'd5) begin
      n_fail++;
      $display("FAIL frame_cnt: cnt4=%0d cnt16=%0d, required 1 5", if4.word_cnt, if16.word_cnt);
    end
    tick();
  endtask

  task automatic test_stall();
    logic [5:0] a;
    logic [5:0] b;
    a = 6'($urandom);
    b = 6'($urandom);
    out_ready = 1'b1;
    do_seed(6'h05);
    in_valid = 1'b1; in_data = a;
    tick();
    out_ready = 1'b0; in_data = b;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++;
      if (if16.in_ready !== 1'b0 || if16.out_valid !== 1'b1 ||
          if16.out_data !== (a ~^ 6'h05) || if16.word_cnt !== 4'd1) begin
        n_fail++;
        $display("FAIL stall_hold cyc %0d: in_ready=%b valid=%b data=%h cnt=%0d, required 0 1 %h 1",
                 i, if16.in_ready, if16.out_valid, if16.out_data, if16.word_cnt, a ~^ 6'h05);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== (b ~^ ks(6'h05, 1)) || if16.word_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL stall_release: valid=%b data=%h cnt=%0d, required 1 %h 2",
               if16.out_valid, if16.out_data, if16.word_cnt, b ~^ ks(6'h05, 1));
    end
    tick();
    n_checks++;
    if (if16.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_drain: out_valid=%b, required 0", if16.out_valid);
    end
  endtask

  task automatic test_seed_priority();
    logic [5:0] c;
    logic [5:0] d;
    c = 6'($urandom);
    d = 6'($urandom);
    out_ready = 1'b1;
    seed_load = 1'b1; seed_in = 6'h15; in_valid = 1'b1; in_data = c;
    @(negedge clk);
    n_checks++;
    if (if16.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL seed_prio_ready: in_ready=%b, required 0", if16.in_ready);
    end
    tick();
    seed_load = 1'b0;
    n_checks++;
    if (if16.out_valid !== 1'b0 || if16.word_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL seed_prio_noacc: valid=%b cnt=%0d, required 0 0", if16.out_valid, if16.word_cnt);
    end
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== (c ~^ 6'h15) || if16.word_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL seed_prio_word: valid=%b data=%h cnt=%0d, required 1 %h 1",
               if16.out_valid, if16.out_data, if16.word_cnt, c ~^ 6'h15);
    end
    // reseed with zero while a word is held
    out_ready = 1'b0;
    do_seed(6'h00);
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== (c ~^ 6'h15) || if16.word_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL seed_held_word: valid=%b data=%h cnt=%0d, required 1 %h 0",
               if16.out_valid, if16.out_data, if16.word_cnt, c ~^ 6'h15);
    end
    out_ready = 1'b1; in_valid = 1'b1; in_data = d;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.out_valid !== 1'b1 || if16.out_data !== (d ~^ 6'h01)) begin
      n_fail++;
      $display("FAIL seed_zero_word: valid=%b data=%h, required 1 %h",
               if16.out_valid, if16.out_data, d ~^ 6'h01);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [5:0] e;
    e = 6'($urandom);
    out_ready = 1'b1;
    do_seed(6'h2A);
    in_valid = 1'b1;
    in_data = 6'($urandom); tick();
    in_data = 6'($urandom); tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.word_cnt !== 4'd2 || if4.word_cnt !== 4'd2 || if16.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre: cnt16=%0d cnt4=%0d valid=%b, required 2 2 1",
               if16.word_cnt, if4.word_cnt, if16.out_valid);
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (if16.out_valid !== 1'b0 || if16.out_data !== 6'h00 || if16.out_last !== 1'b0 ||
        if16.word_cnt !== 4'd0 || state16 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: valid=%b data=%h last=%b cnt=%0d st=%b, required 0 00 0 0 0",
               if16.out_valid, if16.out_data, if16.out_last, if16.word_cnt, state16);
    end
    tick();
    rst_n = 1'b1;
    in_valid = 1'b1; in_data = e;
    @(negedge clk);
    n_checks++;
    if (if16.in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_noseed_ready: in_ready=%b, required 0", if16.in_ready);
    end
    tick();
    in_valid = 1'b0;
    do_seed(6'h2A);
    n_checks++;
    if (if16.word_cnt !== 4'd0 || if16.out_valid !== 1'b0 || state16 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_reseed: cnt=%0d valid=%b st=%b, required 0 0 1",
               if16.word_cnt, if16.out_valid, state16);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    n_checks++;
    if (if16.out_data !== (e ~^ 6'h2A) || if16.word_cnt !== 4'd1) begin
      n_fail++;
      $display("FAIL mid_word: data=%h cnt=%0d, required %h 1", if16.out_data, if16.word_cnt, e ~^ 6'h2A);
    end
    tick();
  endtask

  // Random traffic against the FRAME_LEN=4 instance with a scoreboard.
  task automatic test_random();
    logic [5:0] m_seed;
    int         m_idx;
    logic       m_ov;
    logic       exp_rdy;
    logic       acc;
    int         n_out;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b0;
    m_seed = 6'($urandom_range(1, 63));
    do_seed(m_seed);
    m_idx = 0; m_ov = 1'b0; n_out = 0;
    exp_q.delete();
    for (int cyc = 0; cyc < 400; cyc++) begin
      seed_load = ($urandom_range(0, 29) == 0);
      seed_in   = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = 6'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      exp_rdy = !seed_load && (!m_ov || out_ready);
      n_checks++;
      if (if4.in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_ready cyc %0d: in_ready=%b, required %b", cyc, if4.in_ready, exp_rdy);
      end
      n_checks++;
      if (if4.out_valid !== m_ov || if4.word_cnt !== 4'(m_idx)) begin
        n_fail++;
        $display("FAIL rand_state cyc %0d: valid=%b cnt=%0d, required %b %0d",
                 cyc, if4.out_valid, if4.word_cnt, m_ov, m_idx);
      end
      if (m_ov && exp_q.size() > 0) begin
        n_checks++;
        if ({if4.out_last, if4.out_data} !== exp_q[0]) begin
          n_fail++;
          $display("FAIL rand_data cyc %0d: last=%b data=%h, required %b %h",
                   cyc, if4.out_last, if4.out_data, exp_q[0][6], exp_q[0][5:0]);
        end
      end
      acc = exp_rdy && in_valid;
      if (m_ov && out_ready) begin
        void'(exp_q.pop_front());
        n_out++;
      end
      if (acc) begin
        exp_q.push_back({(m_idx == 3), in_data ~^ ks(m_seed, m_idx)});
        m_idx = (m_idx + 1) % 4;
      end
      m_ov = acc || (m_ov && !out_ready);
      if (seed_load) begin
        m_seed = (seed_in == 6'h00) ? 6'h01 : seed_in;
        m_idx  = 0;
      end
      tick();
    end
    seed_load = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    n_checks++;
    if (n_out < 50) begin
      n_fail++;
      $display("FAIL rand_throughput: %0d words delivered, required at least 50", n_out);
    end
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_frame();
    test_stall();
    test_seed_priority();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
